// File: rtl/tr_defuzzy_pkg.sv
`default_nettype none
// ============================================================================
// tr_defuzzy_pkg : shared FSM encoding and accumulator width helpers
// Revision 1.0
// ============================================================================
package tr_defuzzy_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Sized so that N_SETS worst-case terms never wrap.
  function automatic int den_width(input int w_in, input int n_sets);
    return w_in + 1 + $clog2(n_sets);
  endfunction

  function automatic int num_width(input int w_in, input int pos_w, input int n_sets);
    return w_in + 1 + pos_w + $clog2(n_sets);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tr_div_restoring.sv
`default_nettype none
// ============================================================================
// tr_div_restoring : restoring divider, one quotient bit per cycle, MSB first
// Revision 1.0
// ============================================================================
module tr_div_restoring #(
  parameter int NUM_W = 19,
  parameter int DEN_W = 11,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic [Q_W-1:0]   quotient,
  output logic [DEN_W-1:0] remainder,
  output logic             done
);

  localparam int c_cnt_w = $clog2(Q_W + 1);

  logic [DEN_W-1:0]   r_rem;
  logic [DEN_W-1:0]   r_den;
  logic [Q_W-1:0]     r_low;
  logic [Q_W-1:0]     r_q;
  logic [c_cnt_w-1:0] r_cnt;

  logic [DEN_W:0]   w_trial;
  logic             w_ge;
  logic [DEN_W-1:0] w_rem_next;
  logic [Q_W-1:0]   w_q_next;

  always_comb begin
    w_trial    = {r_rem, r_low[Q_W-1]};
    w_ge       = (w_trial >= {1'b0, r_den});
    w_rem_next = w_ge ? DEN_W'(w_trial - {1'b0, r_den}) : w_trial[DEN_W-1:0];
    w_q_next   = Q_W'({r_q, w_ge});
  end

  // Outputs present the result of the step being taken this cycle, so the
  // caller can capture the final quotient on the same edge that completes it.
  assign quotient  = w_q_next;
  assign remainder = w_rem_next;
  assign done      = (r_cnt == c_cnt_w'(1));

  // The quotient is known to fit in Q_W bits, so the upper DEN_W bits of the
  // dividend are already below den and can seed the partial remainder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem <= '0;
      r_den <= '0;
      r_low <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_rem <= num[NUM_W-1 -: DEN_W];
      r_low <= num[Q_W-1:0];
      r_den <= den;
      r_q   <= '0;
      r_cnt <= c_cnt_w'(Q_W);
    end else if (r_cnt != '0) begin
      r_rem <= w_rem_next;
      r_low <= r_low << 1;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/tr_defuzzy_seq.sv
`default_nettype none
// ============================================================================
// tr_defuzzy_seq : sequential type-reduction defuzzifier, sum(F*pos)/sum(F)
// Revision 1.0
// ============================================================================
module tr_defuzzy_seq
  import tr_defuzzy_pkg::*;
#(
  parameter int N_SETS = 3,
  parameter int W_IN   = 8,
  parameter int POS_W  = 8,
  parameter int ROUND  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    EN_defuzzificador,
  input  logic [N_SETS*W_IN-1:0]  fou_up,
  input  logic [N_SETS*W_IN-1:0]  fou_low,
  input  logic [N_SETS*POS_W-1:0] pos,
  output logic [POS_W-1:0]        saida,
  output logic                    valid,
  output logic                    busy,
  output logic                    div0
);

  localparam int c_den_w = den_width(W_IN, N_SETS);
  localparam int c_num_w = num_width(W_IN, POS_W, N_SETS);
  localparam int c_idx_w = $clog2(N_SETS + 1);
  localparam int c_f_w   = W_IN + 1;
  localparam int c_p_w   = W_IN + 1 + POS_W;

  state_t                  r_state, w_next;
  logic [N_SETS*W_IN-1:0]  r_up, r_low;
  logic [N_SETS*POS_W-1:0] r_pos;
  logic [c_den_w-1:0]      r_den;
  logic [c_num_w-1:0]      r_num;
  logic [c_idx_w-1:0]      r_idx;
  logic [POS_W-1:0]        r_saida;
  logic                    r_valid, r_div0;

  logic [W_IN-1:0]    w_up_sel, w_low_sel;
  logic [POS_W-1:0]   w_pos_sel;
  logic [c_f_w-1:0]   w_f;
  logic [c_p_w-1:0]   w_prod;
  logic               w_acc_last, w_div_load, w_div_done, w_round_up;
  logic [POS_W-1:0]   w_q, w_result;
  logic [c_den_w-1:0] w_rem;

  always_comb begin
    w_up_sel  = '0;
    w_low_sel = '0;
    w_pos_sel = '0;
    for (int i = 0; i < N_SETS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_up_sel  = r_up[i*W_IN +: W_IN];
        w_low_sel = r_low[i*W_IN +: W_IN];
        w_pos_sel = r_pos[i*POS_W +: POS_W];
      end
    end
    w_f        = c_f_w'(w_up_sel) + c_f_w'(w_low_sel);
    w_prod     = c_p_w'(w_f) * c_p_w'(w_pos_sel);
    w_acc_last = (r_idx == c_idx_w'(N_SETS));
    w_round_up = (ROUND != 0) && ({w_rem, 1'b0} >= {1'b0, r_den});
    w_result   = w_q + POS_W'(w_round_up);
  end

  tr_div_restoring #(
    .NUM_W (c_num_w),
    .DEN_W (c_den_w),
    .Q_W   (POS_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (w_div_load),
    .num       (r_num),
    .den       (r_den),
    .quotient  (w_q),
    .remainder (w_rem),
    .done      (w_div_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // ACC runs one extra cycle at idx==N_SETS so the zero test and divider load
  // see the fully registered sums.
  always_comb begin
    w_next     = r_state;
    w_div_load = 1'b0;
    case (r_state)
      S_IDLE: if (EN_defuzzificador) w_next = S_ACC;
      S_ACC: begin
        if (w_acc_last) begin
          if (r_den == '0) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_DIV;
            w_div_load = 1'b1;
          end
        end
      end
      S_DIV:   if (w_div_done) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_up    <= '0;
      r_low   <= '0;
      r_pos   <= '0;
      r_den   <= '0;
      r_num   <= '0;
      r_idx   <= '0;
      r_saida <= '0;
      r_valid <= 1'b0;
      r_div0  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (EN_defuzzificador) begin
            r_up  <= fou_up;
            r_low <= fou_low;
            r_pos <= pos;
            r_den <= '0;
            r_num <= '0;
            r_idx <= '0;
          end
        end
        S_ACC: begin
          if (!w_acc_last) begin
            r_den <= r_den + c_den_w'(w_f);
            r_num <= r_num + c_num_w'(w_prod);
            r_idx <= r_idx + c_idx_w'(1);
          end else if (r_den == '0) begin
            r_saida <= '0;
            r_div0  <= 1'b1;
            r_valid <= 1'b1;
          end
        end
        S_DIV: begin
          if (w_div_done) begin
            r_saida <= w_result;
            r_div0  <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign saida = r_saida;
  assign valid = r_valid;
  assign div0  = r_div0;
  assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tr_defuzzy_seq.sv
`default_nettype none
// ============================================================================
// tb_tr_defuzzy_seq : directed-vector bench for tr_defuzzy_seq
// Revision 1.0
// ============================================================================
module tb_tr_defuzzy_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic [23:0] fou_up = '0, fou_low = '0;
  logic [23:0] pos = {8'd255, 8'd128, 8'd0};
  logic [7:0]  saida, saida_r;
  logic        valid, busy, div0, valid_r, busy_r, div0_r;

  logic        en8 = 1'b0;
  logic [63:0] fou8 = {8{8'd255}};
  logic [63:0] pos8 = {8{8'd255}};
  logic [7:0]  saida8;
  logic        valid8, busy8, div0_8;

  int n_vec = 0;
  int n_err = 0;

  tr_defuzzy_seq dut (
    .clk(clk), .rst(rst), .EN_defuzzificador(en), .fou_up(fou_up), .fou_low(fou_low),
    .pos(pos), .saida(saida), .valid(valid), .busy(busy), .div0(div0));

  tr_defuzzy_seq #(.ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .EN_defuzzificador(en), .fou_up(fou_up), .fou_low(fou_low),
    .pos(pos), .saida(saida_r), .valid(valid_r), .busy(busy_r), .div0(div0_r));

  tr_defuzzy_seq #(.N_SETS(8)) dut8 (
    .clk(clk), .rst(rst), .EN_defuzzificador(en8), .fou_up(fou8), .fou_low(fou8),
    .pos(pos8), .saida(saida8), .valid(valid8), .busy(busy8), .div0(div0_8));

  task automatic start_run(input logic [23:0] up, input logic [23:0] low);
    @(negedge clk);
    fou_up  = up;
    fou_low = low;
    en      = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (saida !== 8'd0) begin n_err++; $display("FAIL reset_saida: got %0d expected 0", saida); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (div0 !== 1'b0)  begin n_err++; $display("FAIL reset_div0: got %b expected 0", div0); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    start_run({8'd30, 8'd20, 8'd10}, {8'd30, 8'd20, 8'd10});
    wait_valid(lat);
    n_vec++; if (lat !== 12)         begin n_err++; $display("FAIL basic_latency: got %0d expected 12", lat); end
    n_vec++; if (saida !== 8'd170)   begin n_err++; $display("FAIL basic_saida: got %0d expected 170", saida); end
    n_vec++; if (div0 !== 1'b0)      begin n_err++; $display("FAIL basic_div0: got %b expected 0", div0); end
    n_vec++; if (dut.r_den !== 11'd120)   begin n_err++; $display("FAIL basic_den: got %0d expected 120", dut.r_den); end
    n_vec++; if (dut.r_num !== 19'd20420) begin n_err++; $display("FAIL basic_num: got %0d expected 20420", dut.r_num); end
    @(posedge clk); #1;
    n_vec++; if (valid !== 1'b0)     begin n_err++; $display("FAIL basic_valid_width: got %b expected 0", valid); end
    n_vec++; if (saida !== 8'd170)   begin n_err++; $display("FAIL basic_saida_hold: got %0d expected 170", saida); end
    @(posedge clk); #1;
    n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_round;
    int lat;
    start_run({8'd0, 8'd0, 8'd1}, {8'd1, 8'd0, 8'd0});
    wait_valid(lat);
    n_vec++; if (lat !== 12)         begin n_err++; $display("FAIL round_latency: got %0d expected 12", lat); end
    n_vec++; if (saida !== 8'd127)   begin n_err++; $display("FAIL round_floor: got %0d expected 127", saida); end
    n_vec++; if (saida_r !== 8'd128) begin n_err++; $display("FAIL round_halfup: got %0d expected 128", saida_r); end
    n_vec++; if (valid_r !== 1'b1)   begin n_err++; $display("FAIL round_valid: got %b expected 1", valid_r); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_div0;
    int lat;
    start_run('0, '0);
    wait_valid(lat);
    n_vec++; if (lat !== 4)        begin n_err++; $display("FAIL div0_latency: got %0d expected 4", lat); end
    n_vec++; if (saida !== 8'd0)   begin n_err++; $display("FAIL div0_saida: got %0d expected 0", saida); end
    n_vec++; if (div0 !== 1'b1)    begin n_err++; $display("FAIL div0_flag: got %b expected 1", div0); end
    repeat (2) @(posedge clk);
    n_vec++; if (div0 !== 1'b1)    begin n_err++; $display("FAIL div0_hold: got %b expected 1", div0); end
    start_run({8'd30, 8'd20, 8'd10}, {8'd30, 8'd20, 8'd10});
    wait_valid(lat);
    n_vec++; if (div0 !== 1'b0)    begin n_err++; $display("FAIL div0_clear: got %b expected 0", div0); end
    n_vec++; if (saida !== 8'd170) begin n_err++; $display("FAIL div0_next_saida: got %0d expected 170", saida); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_retrigger;
    int pulses;
    logic [7:0] got;
    pulses = 0;
    got = '0;
    start_run({8'd30, 8'd20, 8'd10}, {8'd30, 8'd20, 8'd10});
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL retrig_busy: got %b expected 1", busy); end
      end
      if (valid) begin
        pulses++;
        got = saida;
      end
      en = (c == 2 || c == 7);
      if (c == 2) begin
        fou_up  = {8'd0, 8'd0, 8'd99};
        fou_low = {8'd1, 8'd1, 8'd1};
      end
    end
    en = 1'b0;
    n_vec++; if (pulses !== 1)    begin n_err++; $display("FAIL retrig_pulses: got %0d expected 1", pulses); end
    n_vec++; if (got !== 8'd170)  begin n_err++; $display("FAIL retrig_saida: got %0d expected 170", got); end
  endtask

  task automatic test_back_to_back;
    int first, second;
    first = -1;
    second = -1;
    @(negedge clk);
    fou_up  = {8'd0, 8'd0, 8'd1};
    fou_low = {8'd1, 8'd0, 8'd0};
    en = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c == 20) en = 1'b0;
    end
    n_vec++; if (first !== 12)  begin n_err++; $display("FAIL b2b_first: got %0d expected 12", first); end
    n_vec++; if (second !== 26) begin n_err++; $display("FAIL b2b_second: got %0d expected 26", second); end
    n_vec++; if (saida !== 8'd127) begin n_err++; $display("FAIL b2b_saida: got %0d expected 127", saida); end
  endtask

  task automatic test_reset_mid;
    int pulses, lat;
    pulses = 0;
    start_run({8'd30, 8'd20, 8'd10}, {8'd30, 8'd20, 8'd10});
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_vec++; if (saida !== 8'd0) begin n_err++; $display("FAIL rstmid_saida: got %0d expected 0", saida); end
    n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b expected 0", valid); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (valid) pulses++;
    end
    n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL rstmid_novalid: got %0d expected 0", pulses); end
    start_run({8'd30, 8'd20, 8'd10}, {8'd30, 8'd20, 8'd10});
    wait_valid(lat);
    n_vec++; if (lat !== 12)       begin n_err++; $display("FAIL rstmid_latency: got %0d expected 12", lat); end
    n_vec++; if (saida !== 8'd170) begin n_err++; $display("FAIL rstmid_saida2: got %0d expected 170", saida); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_n8;
    int lat;
    lat = -1;
    @(negedge clk);
    en8 = 1'b1;
    @(posedge clk);
    #1;
    en8 = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (valid8) begin
        lat = c;
        break;
      end
    end
    n_vec++; if (lat !== 17)          begin n_err++; $display("FAIL n8_latency: got %0d expected 17", lat); end
    n_vec++; if (saida8 !== 8'd255)   begin n_err++; $display("FAIL n8_saida: got %0d expected 255", saida8); end
    n_vec++; if (div0_8 !== 1'b0)     begin n_err++; $display("FAIL n8_div0: got %b expected 0", div0_8); end
    n_vec++; if (dut8.r_den !== 12'd4080) begin n_err++; $display("FAIL n8_den: got %0d expected 4080", dut8.r_den); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round;
    test_div0;
    test_retrigger;
    test_back_to_back;
    test_reset_mid;
    test_n8;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
